// File: rtl/dcd_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// dcd_scan_ctrl_if
// Bundle between the engine control / state-list storage (master) and the
// decision-variable scanner (slave).
//
// Signals:
//   start_i        master->slave  begin a decision scan (honoured in IDLE only)
//   abort_i        master->slave  synchronous abort, wins over start and ack
//   value_i        master->slave  flattened variable values, var k at [k*WIDTH +: WIDTH]
//   dcd_ack_i      master->slave  consumer accepts the current result
//   busy_o         slave->master  scanner is not idle
//   dcd_valid_o    slave->master  free variable found, index on dcd_idx_o
//   dcd_idx_o      slave->master  index of the locked free variable
//   all_assigned_o slave->master  scan ended without a free variable
//   dbg_state      slave->master  encoded FSM state for observation
//
// Handshake: a result (dcd_valid_o or all_assigned_o) is held stable until
// dcd_ack_i is sampled high on a rising edge; the result is consumed on that
// edge and the flag drops after it. dcd_ack_i has no effect while neither
// flag is up. value_i must be held stable by the master while busy_o is high.
// ---------------------------------------------------------------------------
interface dcd_scan_ctrl_if #(
    parameter int NUM_VARS = 8,
    parameter int WIDTH    = 3,
    parameter int IDX_W    = $clog2(NUM_VARS)
);
    logic                      start_i;
    logic                      abort_i;
    logic [NUM_VARS*WIDTH-1:0] value_i;
    logic                      dcd_ack_i;
    logic                      busy_o;
    logic                      dcd_valid_o;
    logic [IDX_W-1:0]          dcd_idx_o;
    logic                      all_assigned_o;
    logic [1:0]                dbg_state;

    modport master (
        output start_i, abort_i, value_i, dcd_ack_i,
        input  busy_o, dcd_valid_o, dcd_idx_o, all_assigned_o, dbg_state
    );

    modport slave (
        input  start_i, abort_i, value_i, dcd_ack_i,
        output busy_o, dcd_valid_o, dcd_idx_o, all_assigned_o, dbg_state
    );
endinterface

// File: rtl/dcd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// dcd_scan_ctrl
// Sequential decision-variable scanner. On start it walks the variable value
// array one index per cycle from 0, locks onto the first free variable
// (value == 0) and offers its index under a valid/ack handshake, or reports
// that every variable is assigned.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  dcd_scan_ctrl_if slave modport (start/abort/values/ack in,
//        busy/valid/index/all-assigned/debug state out)
// ---------------------------------------------------------------------------
module dcd_scan_ctrl #(
    parameter int NUM_VARS = 8,
    parameter int WIDTH    = 3,
    parameter int IDX_W    = $clog2(NUM_VARS)
) (
    input  logic           clk,
    input  logic           rst,
    dcd_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FOUND  = 2'd2,
        ST_ALLSET = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_scan_cnt;
    logic [IDX_W-1:0] w_next_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_next_idx;
    logic             w_cur_free;

    // Free decode of the variable currently addressed by the scan counter.
    always_comb begin
        w_cur_free = 1'b0;
        for (int k = 0; k < NUM_VARS; k++) begin
            if (r_scan_cnt == IDX_W'(k)) begin
                w_cur_free = (bus.value_i[k*WIDTH +: WIDTH] == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else begin
            r_state    <= w_next_state;
            r_scan_cnt <= w_next_cnt;
            r_idx      <= w_next_idx;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_scan_cnt;
        w_next_idx   = r_idx;
        if (bus.abort_i) begin
            // Abort wins over start and ack; the index register is left alone.
            w_next_state = ST_IDLE;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        w_next_state = ST_SCAN;
                        w_next_cnt   = '0;
                    end
                end
                ST_SCAN: begin
                    if (w_cur_free) begin
                        // Lock: later variables are never examined.
                        w_next_idx   = r_scan_cnt;
                        w_next_state = ST_FOUND;
                    end else if (r_scan_cnt == LAST_IDX) begin
                        // Counter stops here; it never wraps back to 0.
                        w_next_state = ST_ALLSET;
                    end else begin
                        w_next_cnt = r_scan_cnt + 1'b1;
                    end
                end
                ST_FOUND, ST_ALLSET: begin
                    if (bus.dcd_ack_i) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // All outputs are decoded from registered state only.
    assign bus.busy_o         = (r_state != ST_IDLE);
    assign bus.dcd_valid_o    = (r_state == ST_FOUND);
    assign bus.all_assigned_o = (r_state == ST_ALLSET);
    assign bus.dcd_idx_o      = r_idx;
    assign bus.dbg_state      = r_state;

endmodule

// File: tb/tb_dcd_scan_ctrl.sv
module tb_dcd_scan_ctrl;

  localparam int NUM_VARS = 8;
  localparam int WIDTH    = 3;
  localparam int IDX_W    = 3;
  localparam int W        = IDX_W + 1;
  localparam int BUDGET   = 40;

  logic clk;
  logic rst;

  int n_run;
  int n_fail;

  // Expected result {all_assigned, idx} (idx forced to 0 for all-assigned)
  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  dcd_scan_ctrl_if #(.NUM_VARS(NUM_VARS), .WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  dcd_scan_ctrl #(.NUM_VARS(NUM_VARS), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus helpers ----------------
  function automatic logic [NUM_VARS*WIDTH-1:0] make_vals(input logic [NUM_VARS-1:0] free_mask);
    logic [NUM_VARS*WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_VARS; k++) begin
      if (free_mask[k]) v[k*WIDTH +: WIDTH] = '0;
      else              v[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(1, 7));
    end
    return v;
  endfunction

  // Reference: first zero-valued variable from index 0 upward.
  function automatic logic [W-1:0] model_res(input logic [NUM_VARS*WIDTH-1:0] v);
    logic [W-1:0] res;
    logic         found;
    res   = {1'b1, {IDX_W{1'b0}}};
    found = 1'b0;
    for (int k = 0; k < NUM_VARS; k++) begin
      if (!found && v[k*WIDTH +: WIDTH] == '0) begin
        res   = {1'b0, IDX_W'(k)};
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic int model_lat(input logic [NUM_VARS*WIDTH-1:0] v);
    for (int k = 0; k < NUM_VARS; k++) begin
      if (v[k*WIDTH +: WIDTH] == '0) return k + 1;
    end
    return NUM_VARS;
  endfunction

  task automatic push_expect(input logic [NUM_VARS*WIDTH-1:0] v);
    exp_q.push_back(model_res(v));
    lat_q.push_back(model_lat(v));
  endtask

  // Called at a negedge; returns at the negedge where a result is first seen.
  task automatic do_scan(output int lat, output logic busy_e0, output logic [W-1:0] obs);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    busy_e0 = bus.busy_o;
    lat = 0;
    while (!bus.dcd_valid_o && !bus.all_assigned_o && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.dcd_valid_o && !bus.all_assigned_o) lat = -1;
    obs = bus.all_assigned_o ? {1'b1, {IDX_W{1'b0}}} : {1'b0, bus.dcd_idx_o};
  endtask

  task automatic do_ack();
    bus.dcd_ack_i = 1'b1;
    @(negedge clk);
    bus.dcd_ack_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.value_i = make_vals('0);
    n_run++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    n_run++; if (bus.dcd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.dcd_valid_o); end
    n_run++; if (bus.all_assigned_o !== 1'b0) begin n_fail++; $display("FAIL reset_all got=%b exp=0", bus.all_assigned_o); end
    n_run++; if (bus.dcd_idx_o !== '0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", bus.dcd_idx_o); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_assigned();
    int           lat;
    logic         b;
    logic [W-1:0] obs, exp;
    int           el;
    bus.value_i = make_vals('0);
    push_expect(bus.value_i);
    do_scan(lat, b, obs);
    exp = exp_q.pop_front(); el = lat_q.pop_front();
    n_run++; if (b !== 1'b1) begin n_fail++; $display("FAIL allset_busy_e0 got=%b exp=1", b); end
    n_run++; if (obs !== exp) begin n_fail++; $display("FAIL allset_result got=%h exp=%h", obs, exp); end
    n_run++; if (lat !== el) begin n_fail++; $display("FAIL allset_latency got=%0d exp=%0d", lat, el); end
    do_ack();
    n_run++; if (bus.busy_o !== 1'b0 || bus.all_assigned_o !== 1'b0) begin
      n_fail++; $display("FAIL allset_ack got busy=%b all=%b exp 0/0", bus.busy_o, bus.all_assigned_o);
    end
  endtask

  task automatic test_valid_hold();
    int           lat;
    logic         b;
    logic [W-1:0] obs, exp;
    int           el;
    bus.value_i = make_vals(8'b0010_0000);
    push_expect(bus.value_i);
    do_scan(lat, b, obs);
    exp = exp_q.pop_front(); el = lat_q.pop_front();
    n_run++; if (obs !== exp) begin n_fail++; $display("FAIL hold_result got=%h exp=%h", obs, exp); end
    n_run++; if (lat !== el) begin n_fail++; $display("FAIL hold_latency got=%0d exp=%0d", lat, el); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_run++; if (bus.dcd_valid_o !== 1'b1 || bus.dcd_idx_o !== 3'd5) begin
        n_fail++; $display("FAIL hold_cycle%0d got valid=%b idx=%0d exp 1/5", c, bus.dcd_valid_o, bus.dcd_idx_o);
      end
    end
    do_ack();
    n_run++; if (bus.dcd_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL hold_ack got valid=%b busy=%b exp 0/0", bus.dcd_valid_o, bus.busy_o);
    end
  endtask

  task automatic test_first_free();
    int           lat;
    logic         b;
    logic [W-1:0] obs, exp;
    int           el;
    bus.value_i = make_vals(8'b0000_1001);
    push_expect(bus.value_i);
    do_scan(lat, b, obs);
    exp = exp_q.pop_front(); el = lat_q.pop_front();
    n_run++; if (obs !== exp) begin n_fail++; $display("FAIL first_free_result got=%h exp=%h", obs, exp); end
    n_run++; if (lat !== el) begin n_fail++; $display("FAIL first_free_latency got=%0d exp=%0d", lat, el); end
    @(negedge clk);
    n_run++; if (bus.dcd_idx_o !== 3'd0) begin n_fail++; $display("FAIL first_free_locked got=%0d exp=0", bus.dcd_idx_o); end
    do_ack();
  endtask

  task automatic test_back_to_back();
    int           lat;
    logic         b;
    logic [W-1:0] obs, exp;
    int           el;
    bus.value_i = make_vals(8'b1000_0000);
    for (int r = 0; r < 2; r++) begin
      push_expect(bus.value_i);
      do_scan(lat, b, obs);
      exp = exp_q.pop_front(); el = lat_q.pop_front();
      n_run++; if (obs !== exp) begin n_fail++; $display("FAIL b2b%0d_result got=%h exp=%h", r, obs, exp); end
      n_run++; if (lat !== el) begin n_fail++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", r, lat, el); end
      // ack at Ea; do_scan then drives start so it is sampled at Ea+1
      bus.dcd_ack_i = 1'b1;
      @(negedge clk);
      bus.dcd_ack_i = 1'b0;
      n_run++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_ack busy got=%b exp=0", r, bus.busy_o); end
    end
  endtask

  task automatic test_random();
    int           lat;
    logic         b;
    logic [W-1:0] obs, exp;
    int           el;
    for (int r = 0; r < 6; r++) begin
      bus.value_i = make_vals(NUM_VARS'($urandom_range(0, 255)));
      push_expect(bus.value_i);
      do_scan(lat, b, obs);
      exp = exp_q.pop_front(); el = lat_q.pop_front();
      n_run++; if (obs !== exp || lat !== el) begin
        n_fail++; $display("FAIL rand%0d got res=%h lat=%0d exp res=%h lat=%0d", r, obs, lat, exp, el);
      end
      do_ack();
    end
  endtask

  task automatic test_abort();
    int           lat;
    logic         b;
    logic [W-1:0] obs, exp;
    int           el;
    // abort during SCAN at scan_cnt==3, with a start alongside
    bus.value_i = make_vals('0);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    n_run++; if (bus.dbg_state !== 2'd1) begin n_fail++; $display("FAIL abort_pre_state got=%0d exp=1", bus.dbg_state); end
    bus.abort_i = 1'b1;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    bus.start_i = 1'b0;
    n_run++; if (bus.busy_o !== 1'b0 || bus.dcd_valid_o !== 1'b0 || bus.all_assigned_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_scan got busy=%b valid=%b all=%b exp 0/0/0", bus.busy_o, bus.dcd_valid_o, bus.all_assigned_o);
    end
    @(negedge clk);
    n_run++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_start_ignored busy got=%b exp=0", bus.busy_o); end
    // abort in FOUND together with ack
    bus.value_i = make_vals(8'b0000_0100);
    push_expect(bus.value_i);
    do_scan(lat, b, obs);
    exp = exp_q.pop_front(); el = lat_q.pop_front();
    n_run++; if (obs !== exp || lat !== el) begin
      n_fail++; $display("FAIL abort_found_scan got res=%h lat=%0d exp res=%h lat=%0d", obs, lat, exp, el);
    end
    bus.abort_i   = 1'b1;
    bus.dcd_ack_i = 1'b1;
    @(negedge clk);
    bus.abort_i   = 1'b0;
    bus.dcd_ack_i = 1'b0;
    n_run++; if (bus.busy_o !== 1'b0 || bus.dcd_valid_o !== 1'b0 || bus.all_assigned_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_found got busy=%b valid=%b all=%b exp 0/0/0", bus.busy_o, bus.dcd_valid_o, bus.all_assigned_o);
    end
    n_run++; if (bus.dcd_idx_o !== 3'd2) begin n_fail++; $display("FAIL abort_idx_kept got=%0d exp=2", bus.dcd_idx_o); end
  endtask

  task automatic test_async_reset();
    int           lat;
    logic         b;
    logic [W-1:0] obs, exp;
    int           el;
    bus.value_i = make_vals('0);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_run++; if (bus.busy_o !== 1'b0 || bus.dcd_valid_o !== 1'b0 || bus.all_assigned_o !== 1'b0 || bus.dcd_idx_o !== '0) begin
      n_fail++; $display("FAIL async_reset got busy=%b valid=%b all=%b idx=%0d exp 0/0/0/0",
                         bus.busy_o, bus.dcd_valid_o, bus.all_assigned_o, bus.dcd_idx_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.value_i = make_vals(8'b0100_0001);
    push_expect(bus.value_i);
    do_scan(lat, b, obs);
    exp = exp_q.pop_front(); el = lat_q.pop_front();
    n_run++; if (obs !== exp || lat !== el) begin
      n_fail++; $display("FAIL post_reset_scan got res=%h lat=%0d exp res=%h lat=%0d", obs, lat, exp, el);
    end
    do_ack();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    n_run         = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.start_i   = 1'b0;
    bus.abort_i   = 1'b0;
    bus.dcd_ack_i = 1'b0;
    bus.value_i   = '0;
    repeat (2) @(negedge clk);

    test_reset();
    test_all_assigned();
    test_valid_hold();
    test_first_free();
    test_back_to_back();
    test_random();
    test_abort();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dcd_scan_ctrl.md
# dcd_scan_ctrl

Sequential decision-variable scanner for the SAT engine state list. On request it walks the per-variable value array one variable per cycle, starting at index 0. It locks onto the first free (unassigned, value == 0) variable and presents its index to the decision logic under a valid/ack handshake, or reports that every variable is assigned. It sits between the engine's top-level control FSM and the state-list value storage, and sequences the decision search that the per-variable free/lock decode performs combinationally.

## Interface
Parameters:
- NUM_VARS, 8, number of variables in the state list (≥ 2)
- WIDTH, 3, bits per variable value; value 0 means free
- IDX_W, $clog2(NUM_VARS), width of the variable index

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- start_i  input  1  begin a decision scan; honoured only in IDLE
- abort_i  input  1  synchronous abort, e.g. conflict or backtrack; returns to IDLE from any state
- value_i  input  NUM_VARS*WIDTH  flattened variable values; variable k occupies [k*WIDTH +: WIDTH]
- dcd_ack_i  input  1  consumer accepts the current result
- busy_o  output  1  high whenever state != IDLE
- dcd_valid_o  output  1  free variable found; index on dcd_idx_o
- dcd_idx_o  output  IDX_W  index of the locked free variable
- all_assigned_o  output  1  scan finished with no free variable

## Operation
- States: IDLE, SCAN, FOUND, ALLSET. All outputs are registered or decoded from registered state only.
- IDLE: if start_i=1 and abort_i=0, go to SCAN and set scan_cnt=0.
- SCAN, each cycle: examine variable scan_cnt.
  - Variable is free (all WIDTH bits 0): latch dcd_idx_o=scan_cnt and go to FOUND. This is the lock; later variables are not examined.
  - Variable is not free and scan_cnt==NUM_VARS-1: go to ALLSET.
  - Otherwise: scan_cnt += 1.
- FOUND: dcd_valid_o=1 and dcd_idx_o holds its value. On dcd_ack_i=1, go to IDLE.
- ALLSET: all_assigned_o=1. On dcd_ack_i=1, go to IDLE.
- abort_i=1 in any state: next state IDLE, scan_cnt=0, dcd_valid_o=0 and all_assigned_o=0. abort_i has priority over start_i and dcd_ack_i.
- start_i outside IDLE is ignored, including in the cycle where an ack returns the FSM to IDLE.
- dcd_ack_i outside FOUND and ALLSET is ignored.
- value_i is sampled live each SCAN cycle. The upstream block holds it stable while busy_o=1. A change to an already-passed index is not re-examined.
- scan_cnt never wraps. The SCAN exit at NUM_VARS-1 is mandatory.
- dcd_idx_o keeps its last latched value in IDLE and ALLSET. It is meaningful only while dcd_valid_o=1.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, scan_cnt=0, busy_o=0, dcd_valid_o=0, dcd_idx_o=0, all_assigned_o=0.
- Let E0 be the edge that samples start_i=1 in IDLE. busy_o goes high after E0.
- First free variable at index k: dcd_valid_o goes high after edge E(k+1). Scan latency is k+1 cycles.
- No free variable: all_assigned_o goes high after edge E(NUM_VARS).
- Ack sampled at edge Ea: dcd_valid_o or all_assigned_o falls and busy_o falls after Ea.
- The earliest next start is sampled at Ea+1.
- abort_i sampled at edge Eb: every output except dcd_idx_o is 0 after Eb.

## Test plan
- Reset with NUM_VARS=8 and all values nonzero -> all outputs 0. Pulse start -> busy_o=1 after E0, all_assigned_o=1 after E8. Ack -> IDLE, busy_o=0.
- Only variable 5 free -> dcd_valid_o=1 with dcd_idx_o=5 after E6. Valid holds for 3 cycles of no ack, then ack -> valid=0 next cycle.
- Variables 0 and 3 free -> dcd_idx_o=0 after E1. Index 3 is never reported.
- Variable 7 only free -> dcd_idx_o=7 after E8, no ALLSET. Repeat back-to-back: ack at Ea, start at Ea+1 -> second result identical.
- abort_i asserted in SCAN at scan_cnt=3, and again in FOUND with dcd_ack_i=1 in the same cycle -> IDLE next cycle with all flags 0. A start_i asserted together with abort_i is ignored.
- rst asserted mid-SCAN, between clock edges -> outputs go to 0 immediately without waiting for clk. After release, a start pulse scans from index 0.
